// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline sequencer: FSM state encoding,
// valid-chain operation codes and the STAGES/PC_W default values.
package pipe_pkg;

    localparam int unsigned STAGES_DEF = 4;
    localparam int unsigned PC_W_DEF   = 6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPause  = 2'd2,
        StHalted = 2'd3
    } state_e;

    // What the valid/flush chain does on the coming edge.
    typedef enum logic [2:0] {
        OpHold    = 3'd0,
        OpAdvance = 3'd1,
        OpStall   = 3'd2,
        OpBranch  = 3'd3,
        OpHalt    = 3'd4,
        OpClear   = 3'd5
    } chain_op_e;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Control/status bundle between the pipeline sequencer (slave) and its
// environment (master). clk and rst are carried as plain ports instead.
interface pipe_sequencer_if #(
    parameter int unsigned STAGES = pipe_pkg::STAGES_DEF,
    parameter int unsigned PC_W   = pipe_pkg::PC_W_DEF
);
    logic              run_en;
    logic              resume;
    logic              restart;
    logic              halt_req;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_target;
    logic [STAGES-1:0] stall_req;
    logic              step_mode;
    logic              step_req;

    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_flush;
    logic [PC_W-1:0]   pc;
    logic              pc_wrap;
    logic              halted;
    logic [1:0]        state;

    modport master (
        output run_en, resume, restart, halt_req, branch_taken, branch_target,
               stall_req, step_mode, step_req,
        input  stage_en, stage_valid, stage_flush, pc, pc_wrap, halted, state
    );

    modport slave (
        input  run_en, resume, restart, halt_req, branch_taken, branch_target,
               stall_req, step_mode, step_req,
        output stage_en, stage_valid, stage_flush, pc, pc_wrap, halted, state
    );
endinterface

// File: rtl/pipe_valid_chain.sv
// Per-stage valid bits, squash pulses and latch enables, driven by one
// operation code per cycle from the sequencer FSM.
module pipe_valid_chain
    import pipe_pkg::*;
#(
    parameter int unsigned STAGES = STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  chain_op_e         op_i,
    input  logic [STAGES-1:0] stall_i,
    output logic [STAGES-1:0] en_o,
    output logic [STAGES-1:0] valid_o,
    output logic [STAGES-1:0] flush_o
);
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] flush_q, flush_d;
    logic [STAGES-1:0] held, bubble, shifted;

    // held covers stage 0 up to the highest requesting stage; the next one gets the bubble.
    always_comb begin
        held = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            held[i] = |(stall_i >> i);
        end
        bubble  = {held[STAGES-2:0], 1'b0} & ~held;
        shifted = {valid_q[STAGES-2:0], 1'b1};
    end

    always_comb begin
        valid_d = valid_q;
        flush_d = '0;
        en_o    = '0;
        unique case (op_i)
            OpAdvance: begin
                valid_d = shifted;
                en_o    = '1;
            end
            OpStall: begin
                valid_d = (held & valid_q) | (~held & ~bubble & shifted);
                en_o    = ~held;
            end
            OpBranch: begin
                valid_d = {valid_q[STAGES-2], {(STAGES-1){1'b0}}};
                flush_d = {1'b0, {(STAGES-1){1'b1}}};
                en_o    = '1;
            end
            OpHalt: begin
                valid_d = {valid_q[STAGES-1], {(STAGES-1){1'b0}}};
                flush_d = {1'b0, {(STAGES-1){1'b1}}};
            end
            OpClear: begin
                valid_d = '0;
                flush_d = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            flush_q <= '0;
        end else begin
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    assign valid_o = valid_q;
    assign flush_o = flush_q;
endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: IDLE/RUN/PAUSE/HALTED FSM, fetch pc and stage control.
// Optional single-step mode is compiled in with macro PIPE_SINGLE_STEP_EN.
module pipe_sequencer
    import pipe_pkg::*;
#(
    parameter int unsigned STAGES = STAGES_DEF,
    parameter int unsigned PC_W   = PC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_sequencer_if.slave  bus
);
    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_wrap_q, pc_wrap_d;
    logic            step_ok;
    chain_op_e       op;

`ifdef PIPE_SINGLE_STEP_EN
    assign step_ok = !bus.step_mode || bus.step_req;
`else
    logic unused_step;
    assign unused_step = bus.step_mode ^ bus.step_req;
    assign step_ok     = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_wrap_d = 1'b0;
        op        = OpHold;
        unique case (state_q)
            StIdle:   if (bus.run_en) state_d = StRun;
            StPause:  if (bus.run_en) state_d = StRun;
            StHalted: if (bus.resume) state_d = StRun;
            StRun: begin
                if (bus.halt_req) begin
                    state_d = StHalted;
                    op      = OpHalt;
                end else if (!bus.run_en) begin
                    state_d = StPause;
                end else if (!step_ok) begin
                    op = OpHold;
                end else if (bus.branch_taken) begin
                    op   = OpBranch;
                    pc_d = bus.branch_target;
                end else if (|bus.stall_req) begin
                    op = OpStall;
                end else begin
                    op        = OpAdvance;
                    pc_d      = pc_q + PC_W'(1);
                    pc_wrap_d = &pc_q;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.restart) begin
            state_d   = StIdle;
            pc_d      = '0;
            pc_wrap_d = 1'b0;
            op        = OpClear;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            pc_wrap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_wrap_q <= pc_wrap_d;
        end
    end

    pipe_valid_chain #(
        .STAGES (STAGES)
    ) u_chain (
        .clk     (clk),
        .rst     (rst),
        .op_i    (op),
        .stall_i (bus.stall_req),
        .en_o    (bus.stage_en),
        .valid_o (bus.stage_valid),
        .flush_o (bus.stage_flush)
    );

    assign bus.pc      = pc_q;
    assign bus.pc_wrap = pc_wrap_q;
    assign bus.halted  = (state_q == StHalted);
    assign bus.state   = state_q;
endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer (STAGES=4, PC_W=6); the
// single-step scenario follows macro PIPE_SINGLE_STEP_EN.
module tb_pipe_sequencer;
    localparam int unsigned STAGES = 4;
    localparam int unsigned PC_W   = 6;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_sequencer_if #(.STAGES(STAGES), .PC_W(PC_W)) bus ();

    pipe_sequencer #(
        .STAGES (STAGES),
        .PC_W   (PC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.run_en        = 1'b0;
        bus.resume        = 1'b0;
        bus.restart       = 1'b0;
        bus.halt_req      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.stall_req     = '0;
        bus.step_mode     = 1'b0;
        bus.step_req      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Leaves the DUT in RUN with pc=4 and stage_valid=1111.
    task automatic run_to_full();
        do_reset();
        bus.run_en = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.run_en = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.state !== 2'd0 || bus.pc !== 6'h00 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: state=%0d pc=%h halted=%b want 0 00 0",
                     bus.state, bus.pc, bus.halted);
        end
        checks++;
        if (bus.stage_valid !== 4'b0000 || bus.stage_flush !== 4'b0000 ||
            bus.stage_en !== 4'b0000 || bus.pc_wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b flush=%b en=%b wrap=%b want 0000 0000 0000 0",
                     bus.stage_valid, bus.stage_flush, bus.stage_en, bus.pc_wrap);
        end
        rst = 1'b0;
        bus.run_en = 1'b0;
        tick();
        checks++;
        if (bus.state !== 2'd0 || bus.pc !== 6'h00) begin
            failures++;
            $display("FAIL idle_hold: state=%0d pc=%h want 0 00", bus.state, bus.pc);
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_valid [4];
        exp_valid[0] = 4'b0001;
        exp_valid[1] = 4'b0011;
        exp_valid[2] = 4'b0111;
        exp_valid[3] = 4'b1111;
        do_reset();
        bus.run_en = 1'b1;
        tick();
        checks++;
        if (bus.state !== 2'd1 || bus.pc !== 6'h00 || bus.stage_en !== 4'b1111) begin
            failures++;
            $display("FAIL fill_enter_run: state=%0d pc=%h en=%b want 1 00 1111",
                     bus.state, bus.pc, bus.stage_en);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (bus.pc !== PC_W'(j + 1) || bus.stage_valid !== exp_valid[j]) begin
                failures++;
                $display("FAIL fill_step%0d: pc=%h valid=%b want %h %b",
                         j, bus.pc, bus.stage_valid, j + 1, exp_valid[j]);
            end
        end
    endtask

    task automatic test_branch();
        run_to_full();
        tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'h2A;
        #1;
        checks++;
        if (bus.pc !== 6'h05 || bus.stage_en !== 4'b1111) begin
            failures++;
            $display("FAIL branch_pre: pc=%h en=%b want 05 1111", bus.pc, bus.stage_en);
        end
        tick();
        bus.branch_taken = 1'b0;
        checks++;
        if (bus.pc !== 6'h2A || bus.stage_flush !== 4'b0111 || bus.stage_valid !== 4'b1000) begin
            failures++;
            $display("FAIL branch_load: pc=%h flush=%b valid=%b want 2a 0111 1000",
                     bus.pc, bus.stage_flush, bus.stage_valid);
        end
        tick();
        checks++;
        if (bus.pc !== 6'h2B || bus.stage_flush !== 4'b0000) begin
            failures++;
            $display("FAIL branch_after: pc=%h flush=%b want 2b 0000", bus.pc, bus.stage_flush);
        end
    endtask

    task automatic test_stall();
        run_to_full();
        bus.stall_req = 4'b0010;
        #1;
        checks++;
        if (bus.stage_en !== 4'b1100) begin
            failures++;
            $display("FAIL stall_en1: en=%b want 1100", bus.stage_en);
        end
        tick();
        checks++;
        if (bus.pc !== 6'h04 || bus.stage_valid !== 4'b1011 || bus.stage_en !== 4'b1100) begin
            failures++;
            $display("FAIL stall_cycle1: pc=%h valid=%b en=%b want 04 1011 1100",
                     bus.pc, bus.stage_valid, bus.stage_en);
        end
        tick();
        bus.stall_req = 4'b0000;
        checks++;
        if (bus.pc !== 6'h04 || bus.stage_valid !== 4'b0011) begin
            failures++;
            $display("FAIL stall_cycle2: pc=%h valid=%b want 04 0011", bus.pc, bus.stage_valid);
        end
        tick();
        checks++;
        if (bus.pc !== 6'h05 || bus.stage_valid !== 4'b0111) begin
            failures++;
            $display("FAIL stall_release: pc=%h valid=%b want 05 0111", bus.pc, bus.stage_valid);
        end
    endtask

    task automatic test_halt();
        run_to_full();
        tick();
        bus.halt_req      = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'h11;
        #1;
        checks++;
        if (bus.stage_en !== 4'b0000) begin
            failures++;
            $display("FAIL halt_en: en=%b want 0000", bus.stage_en);
        end
        tick();
        bus.halt_req     = 1'b0;
        bus.branch_taken = 1'b0;
        checks++;
        if (bus.halted !== 1'b1 || bus.state !== 2'd3 || bus.pc !== 6'h05) begin
            failures++;
            $display("FAIL halt_enter: halted=%b state=%0d pc=%h want 1 3 05",
                     bus.halted, bus.state, bus.pc);
        end
        checks++;
        if (bus.stage_flush !== 4'b0111 || bus.stage_valid !== 4'b1000) begin
            failures++;
            $display("FAIL halt_flush: flush=%b valid=%b want 0111 1000",
                     bus.stage_flush, bus.stage_valid);
        end
        tick();
        tick();
        checks++;
        if (bus.pc !== 6'h05 || bus.halted !== 1'b1 || bus.stage_en !== 4'b0000) begin
            failures++;
            $display("FAIL halt_frozen: pc=%h halted=%b en=%b want 05 1 0000",
                     bus.pc, bus.halted, bus.stage_en);
        end
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        checks++;
        if (bus.state !== 2'd1 || bus.halted !== 1'b0 || bus.pc !== 6'h05) begin
            failures++;
            $display("FAIL resume_state: state=%0d halted=%b pc=%h want 1 0 05",
                     bus.state, bus.halted, bus.pc);
        end
        tick();
        checks++;
        if (bus.pc !== 6'h06) begin
            failures++;
            $display("FAIL resume_count: pc=%h want 06", bus.pc);
        end
    endtask

    task automatic test_wrap();
        run_to_full();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'h3F;
        tick();
        bus.branch_target = 6'h00;
        tick();
        bus.branch_taken = 1'b0;
        checks++;
        if (bus.pc !== 6'h00 || bus.pc_wrap !== 1'b0) begin
            failures++;
            $display("FAIL branch_to_zero: pc=%h wrap=%b want 00 0", bus.pc, bus.pc_wrap);
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'h3F;
        tick();
        bus.branch_taken = 1'b0;
        checks++;
        if (bus.pc !== 6'h3F || bus.pc_wrap !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pre: pc=%h wrap=%b want 3f 0", bus.pc, bus.pc_wrap);
        end
        tick();
        checks++;
        if (bus.pc !== 6'h00 || bus.pc_wrap !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pulse: pc=%h wrap=%b want 00 1", bus.pc, bus.pc_wrap);
        end
        tick();
        checks++;
        if (bus.pc !== 6'h01 || bus.pc_wrap !== 1'b0) begin
            failures++;
            $display("FAIL wrap_post: pc=%h wrap=%b want 01 0", bus.pc, bus.pc_wrap);
        end
    endtask

    task automatic test_pause();
        run_to_full();
        bus.run_en = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.state !== 2'd2 || bus.pc !== 6'h04 || bus.stage_en !== 4'b0000 ||
            bus.stage_valid !== 4'b1111) begin
            failures++;
            $display("FAIL pause_hold: state=%0d pc=%h en=%b valid=%b want 2 04 0000 1111",
                     bus.state, bus.pc, bus.stage_en, bus.stage_valid);
        end
        bus.run_en = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.state !== 2'd1 || bus.pc !== 6'h05) begin
            failures++;
            $display("FAIL pause_resume: state=%0d pc=%h want 1 05", bus.state, bus.pc);
        end
    endtask

    task automatic test_restart();
        run_to_full();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        checks++;
        if (bus.state !== 2'd0 || bus.pc !== 6'h00 || bus.stage_valid !== 4'b0000 ||
            bus.stage_flush !== 4'b1111) begin
            failures++;
            $display("FAIL restart: state=%0d pc=%h valid=%b flush=%b want 0 00 0000 1111",
                     bus.state, bus.pc, bus.stage_valid, bus.stage_flush);
        end
        bus.run_en = 1'b0;
        tick();
        checks++;
        if (bus.stage_flush !== 4'b0000) begin
            failures++;
            $display("FAIL restart_pulse: flush=%b want 0000", bus.stage_flush);
        end
    endtask

    task automatic test_rst_mid_branch();
        run_to_full();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 6'h2A;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.branch_taken = 1'b0;
        bus.run_en       = 1'b0;
        checks++;
        if (bus.state !== 2'd0 || bus.pc !== 6'h00 || bus.stage_flush !== 4'b0000 ||
            bus.stage_valid !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_branch: state=%0d pc=%h flush=%b valid=%b want 0 00 0000 0000",
                     bus.state, bus.pc, bus.stage_flush, bus.stage_valid);
        end
    endtask

    task automatic test_step();
        run_to_full();
        bus.step_mode = 1'b1;
`ifdef PIPE_SINGLE_STEP_EN
        for (int i = 0; i < 10; i++) begin
            bus.step_req = (i == 1 || i == 4 || i == 7);
            tick();
        end
        bus.step_req = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 6'h07 || bus.stage_en !== 4'b0000) begin
            failures++;
            $display("FAIL step_count: pc=%h en=%b want 07 0000", bus.pc, bus.stage_en);
        end
`else
        bus.step_req = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.pc !== 6'h07 || bus.stage_en !== 4'b1111) begin
            failures++;
            $display("FAIL step_ignored: pc=%h en=%b want 07 1111", bus.pc, bus.stage_en);
        end
`endif
        bus.step_mode = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_fill();
        test_branch();
        test_stall();
        test_halt();
        test_wrap();
        test_pause();
        test_restart();
        test_rst_mid_branch();
        test_step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
